// File: rtl/uart_host_bridge.sv
// Host valid/ready bridge onto the UART chip-select / read-write / tristate data bus.
// Optional interrupt-acknowledge handshake enabled by defining UART_BRIDGE_INT_ACK_EN.
module uart_host_bridge #(
   parameter int unsigned ACCESS_CYCLES  = 3,
   parameter int unsigned RECOVER_CYCLES = 2,
   parameter int unsigned IACK_CYCLES    = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_write_i,
   input  logic [2:0] req_addr_i,
   input  logic [7:0] req_wdata_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_rdata_o,
   output logic       chip_sel_n_o,
   output logic [2:0] address_o,
   output logic       read_write_o,
   inout  wire  [7:0] data_io,
   input  logic       ireq_n_i,
   output logic       iack_o,
   output logic       irq_o,
   input  logic       irq_ack_i
);

   localparam int unsigned PH_MAX = (ACCESS_CYCLES > RECOVER_CYCLES) ? ACCESS_CYCLES : RECOVER_CYCLES;
   localparam int unsigned CNT_W  = $clog2(PH_MAX + 1);
   localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RECOVER,
      ST_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [2:0]       addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             cs_n_q, cs_n_d;
   logic             rw_q, rw_d;
   logic             drive_q, drive_d;
   logic             bus_active_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cs_n_q  <= 1'b1;
         rw_q    <= 1'b1;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cs_n_q  <= cs_n_d;
         rw_q    <= rw_d;
         drive_q <= drive_d;
      end
   end

   // Bus strobes are registered from the next state so chip select never glitches.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               state_d = ST_SETUP;
               wr_d    = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            cnt_d   = ACC_LOAD;
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_RECOVER;
               cnt_d   = REC_LOAD;
               rdata_d = wr_q ? 8'h00 : data_io;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      bus_active_d = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      cs_n_d       = (state_d != ST_ACCESS);
      rw_d         = bus_active_d ? ~wr_d : 1'b1;
      drive_d      = bus_active_d & wr_d;
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign rsp_valid_o  = (state_q == ST_RESP);
   assign rsp_rdata_o  = rdata_q;
   assign chip_sel_n_o = cs_n_q;
   assign address_o    = addr_q;
   assign read_write_o = rw_q;
   assign data_io      = drive_q ? wdata_q : 8'bz;

   logic ireq_s1_q, ireq_s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ireq_s1_q <= 1'b1;
         ireq_s2_q <= 1'b1;
      end else begin
         ireq_s1_q <= ireq_n_i;
         ireq_s2_q <= ireq_s1_q;
      end
   end

`ifdef UART_BRIDGE_INT_ACK_EN
   localparam int unsigned ACK_W = $clog2(IACK_CYCLES + 2);
   localparam logic [ACK_W-1:0] ACK_END  = ACK_W'(IACK_CYCLES);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(IACK_CYCLES + 1);

   logic             ack_mask_q;
   logic [ACK_W-1:0] ack_cnt_q;

   // iack always runs its full width; the mask then waits for ireq release or a timeout.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_mask_q <= 1'b0;
         ack_cnt_q  <= '0;
      end else if (!ack_mask_q) begin
         if (irq_ack_i && !ireq_s2_q) begin
            ack_mask_q <= 1'b1;
            ack_cnt_q  <= '0;
         end
      end else if (ack_cnt_q < ACK_END) begin
         ack_cnt_q <= ack_cnt_q + 1'b1;
      end else if (ireq_s2_q || (ack_cnt_q == ACK_LAST)) begin
         ack_mask_q <= 1'b0;
      end else begin
         ack_cnt_q <= ack_cnt_q + 1'b1;
      end
   end

   assign irq_o  = ~ireq_s2_q & ~ack_mask_q;
   assign iack_o = ack_mask_q & (ack_cnt_q < ACK_END);
`else
   logic unused_irq_ack;

   assign unused_irq_ack = irq_ack_i ^ (IACK_CYCLES == 0);
   assign irq_o          = ~ireq_s2_q;
   assign iack_o         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed self-checking bench for uart_host_bridge; data bus is pulled up so an
// undriven bus reads 8'hFF.
module tb_uart_host_bridge;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       req_valid_i;
   logic       req_ready_o;
   logic       req_write_i;
   logic [2:0] req_addr_i;
   logic [7:0] req_wdata_i;
   logic       rsp_valid_o;
   logic       rsp_ready_i;
   logic [7:0] rsp_rdata_o;
   logic       chip_sel_n_o;
   logic [2:0] address_o;
   logic       read_write_o;
   wire  [7:0] data_io;
   logic       ireq_n_i;
   logic       iack_o;
   logic       irq_o;
   logic       irq_ack_i;

   logic [7:0] tb_drv;
   logic       tb_drv_en;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign data_io = tb_drv_en ? tb_drv : 8'bz;

   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (data_io[g]);
   end

   uart_host_bridge #(
      .ACCESS_CYCLES (3),
      .RECOVER_CYCLES(2),
      .IACK_CYCLES   (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_write_i (req_write_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .chip_sel_n_o(chip_sel_n_o),
      .address_o   (address_o),
      .read_write_o(read_write_o),
      .data_io     (data_io),
      .ireq_n_i    (ireq_n_i),
      .iack_o      (iack_o),
      .irq_o       (irq_o),
      .irq_ack_i   (irq_ack_i)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic w, input logic [2:0] a, input logic [7:0] d, output bit ok);
      req_write_i = w;
      req_addr_i  = a;
      req_wdata_i = d;
      req_valid_i = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = req_ready_o;
         step();
      end
      req_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) step();
      checks++; if (chip_sel_n_o !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", chip_sel_n_o); end
      checks++; if (address_o !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", address_o); end
      checks++; if (read_write_o !== 1'b1) begin failures++; $display("FAIL reset_rw got=%b exp=1", read_write_o); end
      checks++; if (data_io !== 8'hFF) begin failures++; $display("FAIL reset_data got=%h exp=ff", data_io); end
      checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid_o); end
      checks++; if (rsp_rdata_o !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rsp_rdata_o); end
      checks++; if (iack_o !== 1'b0) begin failures++; $display("FAIL reset_iack got=%b exp=0", iack_o); end
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_write();
      bit ok;
      rsp_ready_i = 1'b1;
      send_req(1'b1, 3'd1, 8'hA5, ok);
      checks++; if (!ok) begin failures++; $display("FAIL write_handshake got=timeout exp=accept"); end
      for (int k = 0; k < 8; k++) begin
         checks++; if (chip_sel_n_o !== !(k >= 1 && k <= 3)) begin failures++; $display("FAIL write_cs k=%0d got=%b exp=%b", k, chip_sel_n_o, !(k >= 1 && k <= 3)); end
         checks++; if (read_write_o !== (k > 3)) begin failures++; $display("FAIL write_rw k=%0d got=%b exp=%b", k, read_write_o, (k > 3)); end
         checks++; if (data_io !== ((k <= 3) ? 8'hA5 : 8'hFF)) begin failures++; $display("FAIL write_data k=%0d got=%h exp=%h", k, data_io, (k <= 3) ? 8'hA5 : 8'hFF); end
         checks++; if (rsp_valid_o !== (k == 6)) begin failures++; $display("FAIL write_valid k=%0d got=%b exp=%b", k, rsp_valid_o, (k == 6)); end
         checks++; if (req_ready_o !== (k == 7)) begin failures++; $display("FAIL write_ready k=%0d got=%b exp=%b", k, req_ready_o, (k == 7)); end
         if (k <= 3) begin
            checks++; if (address_o !== 3'd1) begin failures++; $display("FAIL write_addr k=%0d got=%0d exp=1", k, address_o); end
         end
         if (k == 6) begin
            checks++; if (rsp_rdata_o !== 8'h00) begin failures++; $display("FAIL write_rdata got=%h exp=00", rsp_rdata_o); end
         end
         step();
      end
   endtask

   task automatic test_read();
      bit ok;
      rsp_ready_i = 1'b1;
      tb_drv = 8'h3C;
      send_req(1'b0, 3'd0, 8'h00, ok);
      checks++; if (!ok) begin failures++; $display("FAIL read_handshake got=timeout exp=accept"); end
      for (int k = 0; k < 8; k++) begin
         tb_drv_en = (k >= 1 && k <= 3);
         #1;
         checks++; if (chip_sel_n_o !== !(k >= 1 && k <= 3)) begin failures++; $display("FAIL read_cs k=%0d got=%b exp=%b", k, chip_sel_n_o, !(k >= 1 && k <= 3)); end
         checks++; if (read_write_o !== 1'b1) begin failures++; $display("FAIL read_rw k=%0d got=%b exp=1", k, read_write_o); end
         checks++; if (data_io !== ((k >= 1 && k <= 3) ? 8'h3C : 8'hFF)) begin failures++; $display("FAIL read_bus k=%0d got=%h exp=%h", k, data_io, (k >= 1 && k <= 3) ? 8'h3C : 8'hFF); end
         checks++; if (rsp_valid_o !== (k == 6)) begin failures++; $display("FAIL read_valid k=%0d got=%b exp=%b", k, rsp_valid_o, (k == 6)); end
         if (k == 6) begin
            checks++; if (rsp_rdata_o !== 8'h3C) begin failures++; $display("FAIL read_rdata got=%h exp=3c", rsp_rdata_o); end
         end
         step();
      end
      tb_drv_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [2:0] addrs [3];
      logic [7:0] rdexp [3];
      int hs;
      int high_run;
      bit low_seen;
      bit prev_cs;
      addrs = '{3'd2, 3'd5, 3'd7};
      rdexp = '{8'hFF, 8'h00, 8'hFF};
      hs = 0;
      high_run = 0;
      low_seen = 1'b0;
      prev_cs = 1'b1;
      rsp_ready_i = 1'b1;
      for (int t = 0; t < 24; t++) begin
         req_valid_i = (hs < 3);
         req_write_i = (hs == 1);
         req_addr_i  = (hs < 3) ? addrs[hs] : 3'd0;
         req_wdata_i = 8'h5A;
         checks++; if (req_ready_o !== (t % 8 == 0)) begin failures++; $display("FAIL b2b_ready t=%0d got=%b exp=%b", t, req_ready_o, (t % 8 == 0)); end
         checks++; if (chip_sel_n_o !== !(t % 8 >= 2 && t % 8 <= 4)) begin failures++; $display("FAIL b2b_cs t=%0d got=%b exp=%b", t, chip_sel_n_o, !(t % 8 >= 2 && t % 8 <= 4)); end
         checks++; if (rsp_valid_o !== (t % 8 == 7)) begin failures++; $display("FAIL b2b_valid t=%0d got=%b exp=%b", t, rsp_valid_o, (t % 8 == 7)); end
         if (!chip_sel_n_o) begin
            checks++; if (address_o !== addrs[t / 8]) begin failures++; $display("FAIL b2b_addr t=%0d got=%0d exp=%0d", t, address_o, addrs[t / 8]); end
            if (prev_cs && low_seen) begin
               checks++; if (high_run < 3) begin failures++; $display("FAIL b2b_gap t=%0d got=%0d exp>=3", t, high_run); end
            end
            low_seen = 1'b1;
            high_run = 0;
         end else begin
            high_run++;
         end
         if (t % 8 == 7) begin
            checks++; if (rsp_rdata_o !== rdexp[t / 8]) begin failures++; $display("FAIL b2b_rdata t=%0d got=%h exp=%h", t, rsp_rdata_o, rdexp[t / 8]); end
         end
         prev_cs = chip_sel_n_o;
         if (req_valid_i && req_ready_o) hs++;
         step();
      end
      req_valid_i = 1'b0;
   endtask

   task automatic test_backpressure();
      bit ok;
      rsp_ready_i = 1'b0;
      tb_drv = 8'hC3;
      tb_drv_en = 1'b1;
      send_req(1'b0, 3'd6, 8'h00, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_handshake got=timeout exp=accept"); end
      repeat (6) step();
      tb_drv_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, rsp_valid_o); end
         checks++; if (rsp_rdata_o !== 8'hC3) begin failures++; $display("FAIL bp_rdata i=%0d got=%h exp=c3", i, rsp_rdata_o); end
         checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready i=%0d got=%b exp=0", i, req_ready_o); end
         step();
      end
      rsp_ready_i = 1'b1;
      step();
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid_o); end
      checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", req_ready_o); end
      checks++; if (rsp_rdata_o !== 8'hC3) begin failures++; $display("FAIL bp_hold_rdata got=%h exp=c3", rsp_rdata_o); end
   endtask

   task automatic test_reset_abort();
      bit ok;
      rsp_ready_i = 1'b1;
      send_req(1'b1, 3'd4, 8'h99, ok);
      checks++; if (!ok) begin failures++; $display("FAIL abort_handshake got=timeout exp=accept"); end
      step();
      step();
      checks++; if (chip_sel_n_o !== 1'b0) begin failures++; $display("FAIL abort_pre_cs got=%b exp=0", chip_sel_n_o); end
      checks++; if (data_io !== 8'h99) begin failures++; $display("FAIL abort_pre_data got=%h exp=99", data_io); end
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      checks++; if (chip_sel_n_o !== 1'b1) begin failures++; $display("FAIL abort_cs got=%b exp=1", chip_sel_n_o); end
      checks++; if (data_io !== 8'hFF) begin failures++; $display("FAIL abort_data got=%h exp=ff", data_io); end
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", rsp_valid_o); end
      checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", req_ready_o); end
      checks++; if (read_write_o !== 1'b1) begin failures++; $display("FAIL abort_rw got=%b exp=1", read_write_o); end
      checks++; if (rsp_rdata_o !== 8'h00) begin failures++; $display("FAIL abort_rdata got=%h exp=00", rsp_rdata_o); end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (rsp_valid_o !== 1'b0 || chip_sel_n_o !== 1'b1) begin failures++; $display("FAIL abort_quiet i=%0d got=%b%b exp=01", i, rsp_valid_o, chip_sel_n_o); end
      end
   endtask

`ifdef UART_BRIDGE_INT_ACK_EN
   task automatic test_irq_ack();
      ireq_n_i = 1'b0;
      step();
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL ack_sync1 got=%b exp=0", irq_o); end
      step();
      checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL ack_sync2 got=%b exp=1", irq_o); end
      irq_ack_i = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         irq_ack_i = (k == 1);
         checks++; if (iack_o !== (k < 2)) begin failures++; $display("FAIL ack_iack k=%0d got=%b exp=%b", k, iack_o, (k < 2)); end
         checks++; if (irq_o !== (k == 4)) begin failures++; $display("FAIL ack_mask k=%0d got=%b exp=%b", k, irq_o, (k == 4)); end
         if (k < 4) step();
      end
      irq_ack_i = 1'b1;
      ireq_n_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
      for (int j = 0; j < 4; j++) begin
         checks++; if (iack_o !== (j < 2)) begin failures++; $display("FAIL ack2_iack j=%0d got=%b exp=%b", j, iack_o, (j < 2)); end
         checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL ack2_irq j=%0d got=%b exp=0", j, irq_o); end
         step();
      end
   endtask
`else
   task automatic test_irq_pass();
      ireq_n_i = 1'b0;
      step();
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_sync1 got=%b exp=0", irq_o); end
      step();
      checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_sync2 got=%b exp=1", irq_o); end
      irq_ack_i = 1'b1;
      step();
      irq_ack_i = 1'b0;
      checks++; if (iack_o !== 1'b0) begin failures++; $display("FAIL irq_iack got=%b exp=0", iack_o); end
      checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq_o); end
      ireq_n_i = 1'b1;
      step();
      checks++; if (irq_o !== 1'b1) begin failures++; $display("FAIL irq_rel1 got=%b exp=1", irq_o); end
      step();
      checks++; if (irq_o !== 1'b0) begin failures++; $display("FAIL irq_rel2 got=%b exp=0", irq_o); end
   endtask
`endif

   initial begin
      rst_i       = 1'b1;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_addr_i  = 3'd0;
      req_wdata_i = 8'h00;
      rsp_ready_i = 1'b1;
      ireq_n_i    = 1'b1;
      irq_ack_i   = 1'b0;
      tb_drv      = 8'h00;
      tb_drv_en   = 1'b0;
      #1;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_backpressure();
      test_reset_abort();
`ifdef UART_BRIDGE_INT_ACK_EN
      test_irq_ack();
`else
      test_irq_pass();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
